// File: rtl/nivel_comida_gen_pkg.sv
// Shared food-level constants, debounce state encoding and saturating level helpers.
// Also used by the pet state machine and the display block.
package nivel_comida_gen_pkg;

  localparam int NIVEL_W   = 2;
  localparam int NIVEL_SAT = 3;

  typedef enum logic [1:0] {
    ESTABLE_0  = 2'b00,
    CONFIRMA_1 = 2'b01,
    ESTABLE_1  = 2'b11,
    CONFIRMA_0 = 2'b10
  } deb_state_t;

  function automatic logic [NIVEL_W-1:0] sat_inc(input logic [NIVEL_W-1:0] n,
                                                 input logic [NIVEL_W-1:0] tope);
    return (n >= tope) ? tope : n + 1'b1;
  endfunction

  function automatic logic [NIVEL_W-1:0] sat_dec(input logic [NIVEL_W-1:0] n);
    return (n == '0) ? '0 : n - 1'b1;
  endfunction

endpackage

// File: rtl/nivel_comida_gen_antirrebote.sv
// Two-flop synchronizer plus four-state debouncer; clean output is a flop that
// is high in ESTABLE_1 and CONFIRMA_0.
module nivel_comida_gen_antirrebote
  import nivel_comida_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic clean
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  deb_state_t    state;
  deb_state_t    state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      state  <= ESTABLE_0;
      cnt    <= '0;
      clean  <= 1'b0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      state  <= state_next;
      cnt    <= cnt_next;
      clean  <= (state_next == ESTABLE_1) || (state_next == CONFIRMA_0);
    end
  end

  // Confirm states count while the new value holds; any reversion snaps back.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ESTABLE_0: begin
        if (sync_b) begin
          state_next = CONFIRMA_1;
          cnt_next   = '0;
        end
      end
      CONFIRMA_1: begin
        if (!sync_b)               state_next = ESTABLE_0;
        else if (cnt == CNT_LAST)  state_next = ESTABLE_1;
        else                       cnt_next   = cnt + 1'b1;
      end
      ESTABLE_1: begin
        if (!sync_b) begin
          state_next = CONFIRMA_0;
          cnt_next   = '0;
        end
      end
      CONFIRMA_0: begin
        if (sync_b)                state_next = ESTABLE_1;
        else if (cnt == CNT_LAST)  state_next = ESTABLE_0;
        else                       cnt_next   = cnt + 1'b1;
      end
      default: state_next = ESTABLE_0;
    endcase
  end

endmodule

// File: rtl/nivel_comida_gen.sv
// Food level producer: debounced feed button raises the level (when permitted),
// a free-running timer decays it; all outputs registered, feed beats decay.
module nivel_comida_gen
  import nivel_comida_gen_pkg::*;
#(
  parameter int DECAY_CYCLES    = 250_000_000,
  parameter int FAST_DIV        = 10,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int NIVEL_MAX       = NIVEL_SAT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Boton_Comida_raw,
  input  logic               Activo_Comida,
  input  logic               Modo_Test,
  output logic [NIVEL_W-1:0] Nivel_Comida,
  output logic               Boton_Comida,
  output logic               Pulso_Comer,
  output logic               Tick_Decay
);

  localparam int DCW = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;
  localparam logic [DCW-1:0] TC_NORM = DCW'(DECAY_CYCLES - 1);
  localparam logic [DCW-1:0] TC_FAST = DCW'((DECAY_CYCLES / FAST_DIV) - 1);
  localparam logic [NIVEL_W-1:0] TOPE = NIVEL_W'(NIVEL_MAX);

  logic           boton_prev;
  logic           feed;
  logic [DCW-1:0] cnt;
  logic [DCW-1:0] tc;

  nivel_comida_gen_antirrebote #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_antirrebote (
    .clk  (clk),
    .reset(reset),
    .raw  (Boton_Comida_raw),
    .clean(Boton_Comida)
  );

  assign feed = Boton_Comida & ~boton_prev & Activo_Comida;
  assign tc   = Modo_Test ? TC_FAST : TC_NORM;

  // Terminal uses >= so a switch to the short period takes effect at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      boton_prev   <= 1'b0;
      cnt          <= '0;
      Nivel_Comida <= TOPE;
      Pulso_Comer  <= 1'b0;
      Tick_Decay   <= 1'b0;
    end else begin
      boton_prev <= Boton_Comida;
      if (feed) begin
        cnt          <= '0;
        Nivel_Comida <= sat_inc(Nivel_Comida, TOPE);
        Pulso_Comer  <= 1'b1;
        Tick_Decay   <= 1'b0;
      end else if (cnt >= tc) begin
        cnt          <= '0;
        Nivel_Comida <= sat_dec(Nivel_Comida);
        Pulso_Comer  <= 1'b0;
        Tick_Decay   <= 1'b1;
      end else begin
        cnt          <= cnt + 1'b1;
        Pulso_Comer  <= 1'b0;
        Tick_Decay   <= 1'b0;
      end
    end
  end

endmodule

// File: doc/nivel_comida_gen.md
Name: nivel_comida_gen

Overview:
Producer side of the food-level interface: generates the 2-bit Nivel_Comida and the clean Boton_Comida level that the pet state machine consumes. It debounces the raw feed pushbutton and decays the food level on a timer. Each accepted press raises the level, gated by the Activo_Comida permission returned by the state machine. Sits between board I/O and the pet state machine in the top level.

Parameters:
DECAY_CYCLES, 250_000_000, clk cycles per one-step level decay in normal mode (5 s at 50 MHz)
FAST_DIV, 10, decay period divisor when Modo_Test=1 (period = DECAY_CYCLES/FAST_DIV, integer division, must be >=1)
DEBOUNCE_CYCLES, 1_000_000, cycles the synchronized input must stay stable before a level change is accepted (20 ms)
NIVEL_MAX, 3, saturation ceiling and reset value of the level

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (level 0 resets the block)
Boton_Comida_raw  in  1  raw pushbutton, asynchronous, active-high
Activo_Comida  in  1  feeding permitted (from the pet state machine)
Modo_Test  in  1  1 = accelerated decay
Nivel_Comida  out  2  current food level 0..3
Boton_Comida  out  1  debounced button level (to the state machine)
Pulso_Comer  out  1  one-cycle pulse when a feed increment is applied
Tick_Decay  out  1  one-cycle pulse when a decay decrement is applied

Behaviour:
- Reset (reset=0, async): Nivel_Comida=NIVEL_MAX, Boton_Comida=0, Pulso_Comer=0, Tick_Decay=0, decay counter=0, debounce FSM=ESTABLE_0, debounce counter=0, synchronizer flops=0. Reset asserted mid-operation aborts everything immediately; there is no partial state.
- Input path: 2-flop synchronizer on Boton_Comida_raw. Input-to-debouncer latency is 2 cycles.
- Debounce FSM (states ESTABLE_0, CONFIRMA_1, ESTABLE_1, CONFIRMA_0):
  - ESTABLE_0: sync=1 -> CONFIRMA_1, counter cleared.
  - CONFIRMA_1: sync=0 -> ESTABLE_0. Counter reaches DEBOUNCE_CYCLES-1 with sync=1 -> ESTABLE_1.
  - ESTABLE_1: sync=0 -> CONFIRMA_0, counter cleared.
  - CONFIRMA_0: sync=1 -> ESTABLE_1. Counter reaches DEBOUNCE_CYCLES-1 with sync=0 -> ESTABLE_0.
  - Boton_Comida is registered and is 1 in ESTABLE_1 and CONFIRMA_0.
- Feed event: rising edge of Boton_Comida, i.e. the cycle after it goes 0->1.
  - Activo_Comida=1 at that cycle: Nivel_Comida <= min(Nivel_Comida+1, NIVEL_MAX), Pulso_Comer=1 for exactly one cycle, decay counter cleared.
  - Pulso_Comer also pulses at level 3 (saturated increment).
  - Activo_Comida=0: event discarded, no pulse, counter unaffected.
  - A held button gives exactly one event.
- Decay:
  - Terminal TC = Modo_Test ? DECAY_CYCLES/FAST_DIV - 1 : DECAY_CYCLES - 1.
  - Counter increments every cycle.
  - When counter >= TC: counter <= 0, Tick_Decay=1 for one cycle, Nivel_Comida <= max(Nivel_Comida-1, 0).
  - Tick_Decay pulses even at level 0.
  - The >= compare means that switching Modo_Test 0->1 with counter already above the new TC fires on the next cycle.
- Simultaneous feed event and decay terminal in the same cycle: feed wins. Level +1 (saturating), Pulso_Comer=1, Tick_Decay=0, counter <= 0.
- Width rules:
  - Decay counter width is $clog2(DECAY_CYCLES).
  - Debounce counter width is $clog2(DEBOUNCE_CYCLES).
  - Level arithmetic uses explicit saturation, never 2-bit wrap (3+1 stays 3, 0-1 stays 0).
- All outputs are registered. There are no combinational input-to-output paths.

Decomposition:
- Shared package: debounce state encodings (ESTABLE_0=2'b00, CONFIRMA_1=2'b01, ESTABLE_1=2'b11, CONFIRMA_0=2'b10) and NIVEL_MAX/level width constant, reused by the pet state machine and the display block.
- One sub-module: antirrebote (synchronizer + debounce FSM + counter, parameter DEBOUNCE_CYCLES, output clean level). Instantiated once here; reusable for Boton_Medicina.

Test Plan:
Bench parameters for all scenarios: DECAY_CYCLES=20, FAST_DIV=4, DEBOUNCE_CYCLES=3.
1. Release reset, hold inputs 0 for 80 cycles -> Nivel_Comida 3,2,1,0,0 with Tick_Decay at cycles 20,40,60,80 after release.
2. Level 0, Activo_Comida=1, press raw button held 10 cycles -> Boton_Comida rises 2+3 cycles after the raw edge (±1); a single Pulso_Comer; level 1; no second pulse while held.
3. Raw button glitches 1-cycle-high/1-cycle-low for 12 cycles -> Boton_Comida stays 0, no Pulso_Comer, level unchanged.
4. Level 3, valid press -> Pulso_Comer=1, level stays 3, decay counter restarts (next Tick_Decay 20 cycles later). Repeat with Activo_Comida=0 -> no pulse, level and counter unaffected.
5. Align a feed event with decay terminal count at level 2 -> level 3, Pulso_Comer=1, Tick_Decay=0. Modo_Test=1 from reset -> ticks every 5 cycles. Assert reset mid-count -> outputs return to reset values asynchronously.
